// File: rtl/net_link_controller.sv
// Byte-wide four-phase handshake link to the Arduino network node.
// TX sends {dest[7:0], data[31:0]} as 5 bytes; RX assembles 5-byte frames into source ID + payload.
module net_link_controller #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        send,
  input  logic [31:0] net_dest,
  input  logic [31:0] net_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ack,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ack,
  output logic        busy,
  output logic        tx_error,
  output logic        rx_ready,
  output logic        rx_overrun,
  input  logic        rx_clear,
  output logic [7:0]  rx_source,
  output logic [31:0] net_data_arduino
);
  localparam logic [1:0]  T_IDLE  = 2'd0;
  localparam logic [1:0]  T_REQ   = 2'd1;
  localparam logic [1:0]  T_REL   = 2'd2;
  localparam logic [0:0]  R_IDLE  = 1'b0;
  localparam logic [0:0]  R_REL   = 1'b1;
  localparam logic [31:0] TIMEOUT = 32'(TIMEOUT_CYCLES);

  function automatic logic [7:0] tx_byte(input logic [2:0] idx, input logic [7:0] dest,
                                         input logic [31:0] data);
    case (idx)
      3'd0:    tx_byte = dest;
      3'd1:    tx_byte = data[31:24];
      3'd2:    tx_byte = data[23:16];
      3'd3:    tx_byte = data[15:8];
      default: tx_byte = data[7:0];
    endcase
  endfunction

  // Byte 0 lands in the top slot so the buffer reads as {source, payload}.
  function automatic logic [39:0] rx_insert(input logic [39:0] buf_in, input logic [2:0] idx,
                                            input logic [7:0] b);
    rx_insert = buf_in;
    case (idx)
      3'd0:    rx_insert[39:32] = b;
      3'd1:    rx_insert[31:24] = b;
      3'd2:    rx_insert[23:16] = b;
      3'd3:    rx_insert[15:8]  = b;
      default: rx_insert[7:0]   = b;
    endcase
  endfunction

  logic        tx_ack_meta_q, tx_ack_meta_d, tx_ack_sync_q, tx_ack_sync_d;
  logic        rx_valid_meta_q, rx_valid_meta_d, rx_valid_sync_q, rx_valid_sync_d;
  logic [1:0]  tx_state_q, tx_state_d;
  logic [2:0]  tx_idx_q, tx_idx_d;
  logic [31:0] tx_timer_q, tx_timer_d;
  logic [7:0]  tx_dest_q, tx_dest_d;
  logic [31:0] tx_word_q, tx_word_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d, busy_q, busy_d, tx_error_q, tx_error_d;
  logic [0:0]  rx_state_q, rx_state_d;
  logic [2:0]  rx_idx_q, rx_idx_d;
  logic [31:0] rx_timer_q, rx_timer_d;
  logic [39:0] rx_buf_q, rx_buf_d;
  logic        rx_ack_q, rx_ack_d, rx_ready_q, rx_ready_d, rx_overrun_q, rx_overrun_d;
  logic [7:0]  rx_source_q, rx_source_d;
  logic [31:0] rx_payload_q, rx_payload_d;
  logic        rx_commit_s;
  logic        unused_dest_s;

  assign unused_dest_s = ^net_dest[31:8];

  // Two-flop synchronizers for the asynchronous handshake inputs.
  always_comb begin
    tx_ack_meta_d   = tx_ack;
    tx_ack_sync_d   = tx_ack_meta_q;
    rx_valid_meta_d = rx_valid;
    rx_valid_sync_d = rx_valid_meta_q;
  end

  // TX FSM: request/release per byte, phase timer restarts on every state entry.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_idx_d   = tx_idx_q;
    tx_timer_d = tx_timer_q + 32'd1;
    tx_dest_d  = tx_dest_q;
    tx_word_d  = tx_word_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    busy_d     = busy_q;
    tx_error_d = tx_error_q;
    case (tx_state_q)
      T_IDLE: begin
        tx_timer_d = 32'd0;
        if (send) begin
          tx_dest_d  = net_dest[7:0];
          tx_word_d  = net_data;
          tx_error_d = 1'b0;
          busy_d     = 1'b1;
          tx_idx_d   = 3'd0;
          tx_state_d = T_REQ;
          tx_valid_d = 1'b1;
          tx_data_d  = tx_byte(3'd0, net_dest[7:0], net_data);
        end else begin
          tx_valid_d = 1'b0;
        end
      end
      T_REQ: begin
        if (tx_ack_sync_q) begin
          tx_state_d = T_REL;
          tx_valid_d = 1'b0;
          tx_timer_d = 32'd0;
        end else if (tx_timer_q == TIMEOUT) begin
          tx_state_d = T_IDLE;
          tx_valid_d = 1'b0;
          busy_d     = 1'b0;
          tx_error_d = 1'b1;
          tx_timer_d = 32'd0;
        end else begin
          tx_valid_d = 1'b1;
        end
      end
      T_REL: begin
        if (!tx_ack_sync_q) begin
          tx_timer_d = 32'd0;
          if (tx_idx_q == 3'd4) begin
            tx_state_d = T_IDLE;
            busy_d     = 1'b0;
          end else begin
            tx_idx_d   = tx_idx_q + 3'd1;
            tx_state_d = T_REQ;
            tx_valid_d = 1'b1;
            tx_data_d  = tx_byte(tx_idx_q + 3'd1, tx_dest_q, tx_word_q);
          end
        end else if (tx_timer_q == TIMEOUT) begin
          tx_state_d = T_IDLE;
          busy_d     = 1'b0;
          tx_error_d = 1'b1;
          tx_timer_d = 32'd0;
        end else begin
          tx_valid_d = 1'b0;
        end
      end
      default: begin
        tx_state_d = T_IDLE;
        tx_valid_d = 1'b0;
        busy_d     = 1'b0;
        tx_timer_d = 32'd0;
      end
    endcase
  end

  // RX FSM plus frame commit; a commit takes priority over a same-cycle rx_clear.
  always_comb begin
    rx_state_d   = rx_state_q;
    rx_idx_d     = rx_idx_q;
    rx_timer_d   = 32'd0;
    rx_buf_d     = rx_buf_q;
    rx_ack_d     = rx_ack_q;
    rx_ready_d   = rx_ready_q;
    rx_overrun_d = rx_overrun_q;
    rx_source_d  = rx_source_q;
    rx_payload_d = rx_payload_q;
    rx_commit_s  = 1'b0;
    case (rx_state_q)
      R_IDLE: begin
        if (rx_valid_sync_q) begin
          rx_buf_d   = rx_insert(rx_buf_q, rx_idx_q, rx_data);
          rx_ack_d   = 1'b1;
          rx_state_d = R_REL;
        end else if (rx_idx_q != 3'd0) begin
          if (rx_timer_q == TIMEOUT) begin
            rx_idx_d = 3'd0;
          end else begin
            rx_timer_d = rx_timer_q + 32'd1;
          end
        end else begin
          rx_timer_d = 32'd0;
        end
      end
      R_REL: begin
        if (!rx_valid_sync_q) begin
          rx_ack_d   = 1'b0;
          rx_state_d = R_IDLE;
          if (rx_idx_q == 3'd4) begin
            rx_commit_s = 1'b1;
            rx_idx_d    = 3'd0;
          end else begin
            rx_idx_d = rx_idx_q + 3'd1;
          end
        end else begin
          rx_ack_d = 1'b1;
        end
      end
      default: begin
        rx_state_d = R_IDLE;
        rx_ack_d   = 1'b0;
        rx_idx_d   = 3'd0;
      end
    endcase
    if (rx_commit_s) begin
      rx_source_d  = rx_buf_q[39:32];
      rx_payload_d = rx_buf_q[31:0];
      rx_ready_d   = 1'b1;
      rx_overrun_d = rx_overrun_q | rx_ready_q;
    end else if (rx_clear) begin
      rx_ready_d   = 1'b0;
      rx_overrun_d = 1'b0;
    end else begin
      rx_ready_d = rx_ready_q;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_ack_meta_q   <= 1'b0;
      tx_ack_sync_q   <= 1'b0;
      rx_valid_meta_q <= 1'b0;
      rx_valid_sync_q <= 1'b0;
      tx_state_q      <= T_IDLE;
      tx_idx_q        <= 3'd0;
      tx_timer_q      <= 32'd0;
      tx_dest_q       <= 8'd0;
      tx_word_q       <= 32'd0;
      tx_data_q       <= 8'd0;
      tx_valid_q      <= 1'b0;
      busy_q          <= 1'b0;
      tx_error_q      <= 1'b0;
      rx_state_q      <= R_IDLE;
      rx_idx_q        <= 3'd0;
      rx_timer_q      <= 32'd0;
      rx_buf_q        <= 40'd0;
      rx_ack_q        <= 1'b0;
      rx_ready_q      <= 1'b0;
      rx_overrun_q    <= 1'b0;
      rx_source_q     <= 8'd0;
      rx_payload_q    <= 32'd0;
    end else begin
      tx_ack_meta_q   <= tx_ack_meta_d;
      tx_ack_sync_q   <= tx_ack_sync_d;
      rx_valid_meta_q <= rx_valid_meta_d;
      rx_valid_sync_q <= rx_valid_sync_d;
      tx_state_q      <= tx_state_d;
      tx_idx_q        <= tx_idx_d;
      tx_timer_q      <= tx_timer_d;
      tx_dest_q       <= tx_dest_d;
      tx_word_q       <= tx_word_d;
      tx_data_q       <= tx_data_d;
      tx_valid_q      <= tx_valid_d;
      busy_q          <= busy_d;
      tx_error_q      <= tx_error_d;
      rx_state_q      <= rx_state_d;
      rx_idx_q        <= rx_idx_d;
      rx_timer_q      <= rx_timer_d;
      rx_buf_q        <= rx_buf_d;
      rx_ack_q        <= rx_ack_d;
      rx_ready_q      <= rx_ready_d;
      rx_overrun_q    <= rx_overrun_d;
      rx_source_q     <= rx_source_d;
      rx_payload_q    <= rx_payload_d;
    end
  end

  assign tx_data          = tx_data_q;
  assign tx_valid         = tx_valid_q;
  assign busy             = busy_q;
  assign tx_error         = tx_error_q;
  assign rx_ack           = rx_ack_q;
  assign rx_ready         = rx_ready_q;
  assign rx_overrun       = rx_overrun_q;
  assign rx_source        = rx_source_q;
  assign net_data_arduino = rx_payload_q;
endmodule

// File: tb/tb_net_link_controller.sv
// Self-checking bench for net_link_controller: the bench plays the Arduino on both
// directions and keeps a frame-level reference model of the RX result registers.
module tb_net_link_controller;
  localparam int TO = 20;

  logic        clock = 1'b0;
  logic        reset, send, tx_ack, rx_valid, rx_clear;
  logic [31:0] net_dest, net_data;
  logic [7:0]  rx_data;
  logic [7:0]  tx_data, rx_source;
  logic        tx_valid, rx_ack, busy, tx_error, rx_ready, rx_overrun;
  logic [31:0] net_data_arduino;

  always #5 clock = ~clock;

  net_link_controller #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .send(send), .net_dest(net_dest), .net_data(net_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ack(tx_ack), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ack(rx_ack), .busy(busy), .tx_error(tx_error),
    .rx_ready(rx_ready), .rx_overrun(rx_overrun), .rx_clear(rx_clear),
    .rx_source(rx_source), .net_data_arduino(net_data_arduino)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model of the RX result registers, updated per whole frame.
  logic        ref_ready = 1'b0;
  logic        ref_overrun = 1'b0;
  logic [7:0]  ref_source = 8'd0;
  logic [31:0] ref_payload = 32'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_data"},  {24'd0, tx_data},  32'd0);
    check({tag, "_tx_valid"}, {31'd0, tx_valid}, 32'd0);
    check({tag, "_rx_ack"},   {31'd0, rx_ack},   32'd0);
    check({tag, "_busy"},     {31'd0, busy},     32'd0);
    check({tag, "_tx_error"}, {31'd0, tx_error}, 32'd0);
    check({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
    check({tag, "_overrun"},  {31'd0, rx_overrun}, 32'd0);
    check({tag, "_source"},   {24'd0, rx_source}, 32'd0);
    check({tag, "_payload"},  net_data_arduino,  32'd0);
  endtask

  task automatic check_rx_model(input string tag);
    check({tag, "_ready"},   {31'd0, rx_ready},   {31'd0, ref_ready});
    check({tag, "_overrun"}, {31'd0, rx_overrun}, {31'd0, ref_overrun});
    check({tag, "_source"},  {24'd0, rx_source},  {24'd0, ref_source});
    check({tag, "_payload"}, net_data_arduino,    ref_payload);
  endtask

  task automatic do_send(input logic [31:0] dest, input logic [31:0] data);
    net_dest = dest;
    net_data = data;
    send = 1'b1;
    @(negedge clock);
    send = 1'b0;
    check("send_busy_rise",  {31'd0, busy},     32'd1);
    check("send_valid_rise", {31'd0, tx_valid}, 32'd1);
  endtask

  // Acknowledge nbytes TX bytes; expected byte b comes straight from the frame layout.
  task automatic tx_serve(input logic [7:0] dest, input logic [31:0] data, input int dly,
                          input int nbytes);
    logic [7:0] exp;
    int t;
    for (int b = 0; b < nbytes; b++) begin
      exp = (b == 0) ? dest : 8'(data >> (8 * (4 - b)));
      t = 0;
      while (!tx_valid && t < 100) begin @(negedge clock); t++; end
      check("tx_valid_seen", {31'd0, tx_valid}, 32'd1);
      check($sformatf("tx_byte%0d", b), {24'd0, tx_data}, {24'd0, exp});
      repeat (dly) @(negedge clock);
      tx_ack = 1'b1;
      t = 0;
      while (tx_valid && t < 100) begin @(negedge clock); t++; end
      check("tx_ack_latency", 32'(t), 32'd3);
      check("tx_busy_mid", {31'd0, busy}, 32'd1);
      repeat (dly) @(negedge clock);
      tx_ack = 1'b0;
    end
    if (nbytes == 5) begin
      t = 0;
      while (busy && t < 100) begin @(negedge clock); t++; end
      check("tx_busy_fall_latency", 32'(t), 32'd3);
      check("tx_error_after_frame", {31'd0, tx_error}, 32'd0);
    end
  endtask

  // Arduino-side RX: send nbytes of frame (byte 0 = frame[39:32]); optional rx_clear on commit cycle.
  task automatic rx_send(input logic [39:0] frame, input int nbytes, input int dly, input bit clr);
    int t;
    for (int b = 0; b < nbytes; b++) begin
      rx_data  = frame[39 - 8 * b -: 8];
      rx_valid = 1'b1;
      t = 0;
      while (!rx_ack && t < 100) begin @(negedge clock); t++; end
      check("rx_ack_rise_latency", 32'(t), 32'd3);
      repeat (dly) @(negedge clock);
      rx_valid = 1'b0;
      t = 0;
      while (rx_ack && t < 100) begin
        if (clr && b == 4 && t == 2) rx_clear = 1'b1;
        @(negedge clock);
        rx_clear = 1'b0;
        t++;
      end
      check("rx_ack_fall_latency", 32'(t), 32'd3);
      rx_data = 8'($urandom);
    end
    if (nbytes == 5) begin
      ref_overrun = ref_overrun | ref_ready;
      ref_ready   = 1'b1;
      ref_source  = frame[39:32];
      ref_payload = frame[31:0];
      check_rx_model("rx_commit");
    end
  endtask

  task automatic pulse_clear();
    rx_clear = 1'b1;
    @(negedge clock);
    rx_clear = 1'b0;
    ref_ready   = 1'b0;
    ref_overrun = 1'b0;
    check_rx_model("rx_clear");
  endtask

  initial begin
    logic [31:0] d, x;
    logic [39:0] f;
    int t;
    reset = 1'b1; send = 1'b0; tx_ack = 1'b0; rx_valid = 1'b0; rx_clear = 1'b0;
    net_dest = 32'd0; net_data = 32'd0; rx_data = 8'd0;
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clock);

    // Directed TX frame then a few randomized ones.
    do_send(32'h0000_0007, 32'hDEAD_BEEF);
    tx_serve(8'h07, 32'hDEAD_BEEF, 2, 5);
    for (int i = 0; i < 3; i++) begin
      d = $urandom; x = $urandom;
      do_send(d, x);
      tx_serve(d[7:0], x, int'($urandom_range(0, 3)), 5);
    end

    // TX timeout with no acknowledge, then recovery.
    do_send(32'h0000_0011, 32'h0102_0304);
    t = 1;
    while (tx_valid && t < 100) begin @(negedge clock); t++; end
    check("tx_timeout_window", {31'd0, (t >= TO && t <= TO + 3)}, 32'd1);
    check("tx_timeout_error", {31'd0, tx_error}, 32'd1);
    check("tx_timeout_busy", {31'd0, busy}, 32'd0);
    d = $urandom; x = $urandom;
    do_send(d, x);
    check("tx_error_cleared_by_send", {31'd0, tx_error}, 32'd0);
    tx_serve(d[7:0], x, 1, 5);

    // RX directed frame, clear, overrun and clear coinciding with commit.
    rx_send(40'h03_1234_5678, 5, 1, 1'b0);
    pulse_clear();
    rx_send({8'($urandom), 32'($urandom)}, 5, 0, 1'b0);
    rx_send({8'($urandom), 32'($urandom)}, 5, 2, 1'b0);
    rx_send({8'($urandom), 32'($urandom)}, 5, 1, 1'b1);
    pulse_clear();

    // Partial frame dropped after an idle gap beyond the timeout.
    rx_send({8'($urandom), 32'($urandom)}, 2, 1, 1'b0);
    repeat (TO + 10) @(negedge clock);
    check_rx_model("rx_partial_gap");
    rx_send(40'h09_0000_0001, 5, 1, 1'b0);
    pulse_clear();

    // TX and RX running concurrently.
    d = $urandom; x = $urandom; f = {8'($urandom), 32'($urandom)};
    fork
      begin do_send(d, x); tx_serve(d[7:0], x, 1, 5); end
      begin rx_send(f, 5, 2, 1'b0); end
    join

    // A second send while busy is ignored; reset during TX byte 2 clears everything.
    d = $urandom; x = $urandom;
    do_send(d, x);
    net_dest = ~d; net_data = ~x; send = 1'b1;
    @(negedge clock);
    send = 1'b0;
    fork
      tx_serve(d[7:0], x, 1, 2);
      rx_send({8'($urandom), 32'($urandom)}, 2, 0, 1'b0);
    join
    t = 0;
    while (!tx_valid && t < 100) begin @(negedge clock); t++; end
    check("tx_byte2_before_reset", {24'd0, tx_data}, {24'd0, x[23:16]});
    reset = 1'b1; rx_valid = 1'b0; tx_ack = 1'b0;
    @(negedge clock);
    check_reset_outputs("midframe_reset");
    reset = 1'b0;
    ref_ready = 1'b0; ref_overrun = 1'b0; ref_source = 8'd0; ref_payload = 32'd0;
    @(negedge clock);
    rx_send({8'($urandom), 32'($urandom)}, 5, 1, 1'b0);
    d = $urandom; x = $urandom;
    do_send(d, x);
    tx_serve(d[7:0], x, 0, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule

// File: doc/net_link_controller.md
# net_link_controller

Byte-wide four-phase handshake link between the processor and the external Arduino network node. It sits downstream of the datapath's network registers: it consumes `netDest`/`netData` on a send command and transmits a 5-byte frame. It sits upstream of the datapath's `netDataArduino` input: it assembles received 5-byte frames into a held 32-bit word plus source ID. The control unit stalls on `busy` and polls `rx_ready`.

## Interface
- `TIMEOUT_CYCLES`, default 1000000: maximum cycles spent waiting for one handshake phase (TX) or between received bytes (RX).
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `send`  in  1  one-cycle command from control unit to start a frame.
- `net_dest`  in  32  destination register value; only bits [7:0] are transmitted.
- `net_data`  in  32  payload register value.
- `tx_data`  out  8  byte presented to the Arduino.
- `tx_valid`  out  1  TX handshake request.
- `tx_ack`  in  1  TX acknowledge from the Arduino (asynchronous).
- `rx_data`  in  8  byte from the Arduino; stable while `rx_valid` is high.
- `rx_valid`  in  1  RX request from the Arduino (asynchronous).
- `rx_ack`  out  1  RX acknowledge.
- `busy`  out  1  TX frame in progress.
- `tx_error`  out  1  sticky flag: last TX frame aborted by timeout.
- `rx_ready`  out  1  sticky flag: complete frame held.
- `rx_overrun`  out  1  sticky flag: a frame overwrote an unread frame.
- `rx_clear`  in  1  one-cycle pulse; clears `rx_ready` and `rx_overrun`.
- `rx_source`  out  8  first byte of the last complete RX frame.
- `net_data_arduino`  out  32  payload of the last complete RX frame.

## Operation
- `tx_ack` and `rx_valid` each pass through a 2-flop synchronizer. All FSM decisions use the synchronized copies.
- **TX frame order:** byte0 = `net_dest[7:0]`, byte1 = `net_data[31:24]`, byte2 = `[23:16]`, byte3 = `[15:8]`, byte4 = `[7:0]`.
- **TX capture:** `send` while `busy`=0 latches `net_dest[7:0]` and `net_data` and clears `tx_error`. `send` while `busy`=1 is ignored.
- **TX FSM:**
  - T_IDLE → T_REQ on accepted `send`. Set `busy`=1, byte index = 0.
  - T_REQ: drive `tx_data` = current byte, `tx_valid`=1, wait for synced ack = 1 → T_REL.
  - T_REL: `tx_valid`=0, wait for synced ack = 0. If index = 4 → T_IDLE with `busy`=0; else index+1 → T_REQ.
  - Phase timer clears on every state entry. If it reaches `TIMEOUT_CYCLES` in T_REQ or T_REL → T_IDLE, `tx_valid`=0, `busy`=0, `tx_error`=1.
- `tx_data` holds its last value when idle.
- **RX FSM:**
  - R_IDLE: on synced valid = 1, capture `rx_data` into byte slot [index] and set `rx_ack`=1 → R_REL.
  - R_REL: wait for synced valid = 0, then `rx_ack`=0. If index = 4, commit the frame and set index = 0; else index+1. Return to R_IDLE.
  - Commit: `rx_source` = byte0, `net_data_arduino` = {byte1, byte2, byte3, byte4}, `rx_ready`=1. If `rx_ready` was already 1, also set `rx_overrun`=1.
  - Partial-frame timeout: in R_IDLE with index ≠ 0, an idle gap reaching `TIMEOUT_CYCLES` discards the partial frame (index = 0). Outputs are unchanged.
  - R_REL waits indefinitely; there is no timeout there.
- Commit and `rx_clear` in the same cycle: commit wins. `rx_ready`=1, and `rx_overrun` follows the pre-clear rule.
- TX and RX are fully independent and may run concurrently.
- `reset` mid-frame aborts both FSMs immediately and discards partial data.

## Timing
- Reset values: `tx_data`=0, `tx_valid`=0, `rx_ack`=0, `busy`=0, `tx_error`=0, `rx_ready`=0, `rx_overrun`=0, `rx_source`=0, `net_data_arduino`=0. Synchronizers are cleared.
- All outputs are registered.
- `busy` and `tx_valid` rise in the cycle after `send`.
- A `tx_ack` edge becomes visible 2 cycles later; `tx_valid` changes 1 cycle after that (3 cycles from edge to response).
- With an ideal ack that responds immediately, each byte costs at least 6 cycles.
- RX: `rx_ack` rises 3 cycles after `rx_valid` rises. After `rx_valid` falls on the last byte, `rx_ack` falls and the committed outputs appear in the same cycle, 3 cycles after the fall.
- Timeout fires when the phase counter equals `TIMEOUT_CYCLES`. The counter is at least 32 bits wide.

## Test plan
- **TX frame:** `net_dest`=0x00000007, `net_data`=0xDEADBEEF, `send` pulse, bench acks each byte with 2-cycle delay → `tx_data` sequence 07, DE, AD, BE, EF; `busy` drops after the final ack release; `tx_error`=0.
- **TX timeout:** `TIMEOUT_CYCLES`=20, no ack → `tx_valid` falls and `tx_error`=1 at cycle 20 of T_REQ. A new `send` clears `tx_error`.
- **RX frame:** Arduino sends 03, 12, 34, 56, 78 → `rx_source`=0x03, `net_data_arduino`=0x12345678, `rx_ready`=1; `rx_clear` → `rx_ready`=0.
- **RX overrun:** two frames without `rx_clear` → second payload held, `rx_overrun`=1. A `rx_clear` coinciding with a third commit leaves `rx_ready`=1.
- **Partial drop:** 2 bytes, gap > `TIMEOUT_CYCLES`, then full frame 09, 00, 00, 00, 01 → `net_data_arduino`=0x00000001, `rx_source`=0x09.
- **Concurrency and reset:** `send` during RX; assert `reset` in byte 2 of TX → all outputs return to reset values next cycle; `send` while `busy`=1 is ignored.
